// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// stage bit indices, FSM encodings and the per-stage stall/flush masks.
package pipe_ctrl_pkg;

    localparam int STG_PC    = 0;
    localparam int STG_IFID  = 1;
    localparam int STG_IDEX  = 2;
    localparam int STG_EXMEM = 3;
    localparam int STG_WB    = 4;
    localparam int NUM_STG   = 5;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_DIV_WAIT   = 2'd1;
    localparam logic [1:0] ST_TRAP_DRAIN = 2'd2;
    localparam logic [1:0] ST_TRAP_JUMP  = 2'd3;

    // Stage masks, bit0 = PC ... bit4 = MEM/WB
    localparam logic [NUM_STG-1:0] MASK_NONE      = 5'b00000;
    localparam logic [NUM_STG-1:0] MASK_ALL       = 5'b11111;
    localparam logic [NUM_STG-1:0] MASK_PC        = 5'b00001;
    localparam logic [NUM_STG-1:0] MASK_IFID      = 5'b00010;
    localparam logic [NUM_STG-1:0] MASK_IDEX      = 5'b00100;
    localparam logic [NUM_STG-1:0] MASK_WB        = 5'b10000;
    localparam logic [NUM_STG-1:0] MASK_FRONT     = 5'b00011;
    localparam logic [NUM_STG-1:0] MASK_FRONT_EX  = 5'b00110;
    localparam logic [NUM_STG-1:0] MASK_UPTO_MEM  = 5'b01111;
    localparam logic [NUM_STG-1:0] MASK_DRAIN     = 5'b01110;

    typedef struct packed {
        logic [NUM_STG-1:0] stall;
        logic [NUM_STG-1:0] flush;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_load_use_det.sv
// Load-use hazard comparator: flags an ID instruction that reads the
// destination of a load currently in EX (x0 never hazards).
module load_use_det
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_IDX_W = 5
) (
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_rd,
    input  logic                 id_rs2_rd,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] ex_rd,
    output logic                 hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = id_rs1_rd && (id_rs1 == ex_rd);
    assign rs2_hit = id_rs2_rd && (id_rs2 == ex_rd);
    assign hazard  = ex_is_load && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and sequencing controller: per-stage stall/flush, PC
// redirect for branches and traps, divide/memory wait sequencing, stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_rs1_rd,
    input  logic                 id_rs2_rd,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 ex_branch_taken,
    input  logic [ADDR_W-1:0]    ex_branch_target,
    input  logic                 ex_div_start,
    input  logic                 div_done,
    input  logic                 mem_busy,
    input  logic                 trap_req,
    input  logic [ADDR_W-1:0]    trap_vector,
    output logic [4:0]           stall_o,
    output logic [4:0]           flush_o,
    output logic                 redirect_o,
    output logic [ADDR_W-1:0]    redirect_addr_o,
    output logic                 trap_ack_o,
    output logic [CNT_W-1:0]     stall_cycles_o
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] trap_vec_q;
    logic              vec_load;
    logic              load_use;
    ctrl_t             ctrl;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              ack;

    load_use_det #(.REG_IDX_W(REG_IDX_W)) u_load_use_det (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rs1_rd  (id_rs1_rd),
        .id_rs2_rd  (id_rs2_rd),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .hazard     (load_use)
    );

    // RUN resolves hazards by fixed priority; a trap is only accepted from RUN,
    // so a request raised during a divide waits for the divide to finish.
    always_comb begin
        ctrl          = '{stall: MASK_NONE, flush: MASK_NONE};
        redirect      = 1'b0;
        redirect_addr = '0;
        ack           = 1'b0;
        vec_load      = 1'b0;
        state_nxt     = state;
        case (state)
            ST_RUN: begin
                if (trap_req) begin
                    ctrl      = '{stall: MASK_PC, flush: MASK_DRAIN};
                    vec_load  = 1'b1;
                    state_nxt = ST_TRAP_DRAIN;
                end else if (mem_busy) begin
                    ctrl = '{stall: MASK_ALL, flush: MASK_NONE};
                end else if (ex_div_start) begin
                    ctrl      = '{stall: MASK_UPTO_MEM, flush: MASK_WB};
                    state_nxt = ST_DIV_WAIT;
                end else if (ex_branch_taken) begin
                    ctrl          = '{stall: MASK_NONE, flush: MASK_FRONT_EX};
                    redirect      = 1'b1;
                    redirect_addr = ex_branch_target;
                end else if (load_use) begin
                    ctrl = '{stall: MASK_FRONT, flush: MASK_IDEX};
                end
            end
            ST_DIV_WAIT: begin
                if (div_done) begin
                    state_nxt = ST_RUN;
                end else if (mem_busy) begin
                    ctrl = '{stall: MASK_ALL, flush: MASK_NONE};
                end else begin
                    ctrl = '{stall: MASK_UPTO_MEM, flush: MASK_WB};
                end
            end
            ST_TRAP_DRAIN: begin
                ctrl = '{stall: MASK_PC, flush: MASK_DRAIN};
                if (!mem_busy) begin
                    state_nxt = ST_TRAP_JUMP;
                end
            end
            ST_TRAP_JUMP: begin
                ctrl          = '{stall: MASK_NONE, flush: MASK_IFID};
                redirect      = 1'b1;
                redirect_addr = trap_vec_q;
                ack           = 1'b1;
                state_nxt     = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    assign stall_o         = rst ? MASK_NONE : ctrl.stall;
    assign flush_o         = rst ? MASK_NONE : ctrl.flush;
    assign redirect_o      = rst ? 1'b0 : redirect;
    assign redirect_addr_o = rst ? '0 : redirect_addr;
    assign trap_ack_o      = rst ? 1'b0 : ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_RUN;
            trap_vec_q     <= '0;
            stall_cycles_o <= '0;
        end else begin
            state <= state_nxt;
            if (vec_load) begin
                trap_vec_q <= trap_vector;
            end
            if (stall_o[STG_PC]) begin
                stall_cycles_o <= stall_cycles_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: vector table, directed multi-cycle
// sequences and a randomized run against a behavioural model.
module tb_pipe_ctrl;

    localparam int ADDR_W    = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic [REG_IDX_W-1:0] id_rs1, id_rs2, ex_rd;
    logic                 id_rs1_rd, id_rs2_rd, ex_is_load;
    logic                 ex_branch_taken, ex_div_start, div_done, mem_busy, trap_req;
    logic [ADDR_W-1:0]    ex_branch_target, trap_vector;
    logic [4:0]           stall_o, flush_o;
    logic                 redirect_o, trap_ack_o;
    logic [ADDR_W-1:0]    redirect_addr_o;
    logic [CNT_W-1:0]     stall_cycles_o;

    pipe_ctrl #(.ADDR_W(ADDR_W), .REG_IDX_W(REG_IDX_W), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_rs1_rd        (id_rs1_rd),
        .id_rs2_rd        (id_rs2_rd),
        .ex_is_load       (ex_is_load),
        .ex_rd            (ex_rd),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .ex_div_start     (ex_div_start),
        .div_done         (div_done),
        .mem_busy         (mem_busy),
        .trap_req         (trap_req),
        .trap_vector      (trap_vector),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .redirect_o       (redirect_o),
        .redirect_addr_o  (redirect_addr_o),
        .trap_ack_o       (trap_ack_o),
        .stall_cycles_o   (stall_cycles_o)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  rs1, rs2, rd;
        logic        rs1_rd, rs2_rd, is_load;
        logic        br;
        logic [31:0] tgt;
        logic        div_start, div_done, mem_busy, trap_req;
        logic [31:0] vec;
    } in_t;

    typedef struct {
        logic [4:0]  stall, flush;
        logic        redirect;
        logic [31:0] addr;
        logic        ack;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Behavioural model state
    bit          m_div, m_drain, m_jump;
    logic [31:0] m_vec;
    logic [31:0] m_cnt;

    function automatic in_t idle_in();
        in_t x;
        x.rst = 0; x.rs1 = 0; x.rs2 = 0; x.rd = 0; x.rs1_rd = 0; x.rs2_rd = 0;
        x.is_load = 0; x.br = 0; x.tgt = 0; x.div_start = 0; x.div_done = 0;
        x.mem_busy = 0; x.trap_req = 0; x.vec = 0;
        return x;
    endfunction

    function automatic out_t mk_out(logic [4:0] s, logic [4:0] f, logic r, logic [31:0] a, logic k);
        out_t o;
        o.stall = s; o.flush = f; o.redirect = r; o.addr = a; o.ack = k;
        return o;
    endfunction

    function automatic in_t lu_in(logic [4:0] rs1, logic rs1_rd, logic [4:0] rs2, logic rs2_rd,
                                  logic is_load, logic [4:0] rd, logic br, logic [31:0] tgt, logic mb);
        in_t x = idle_in();
        x.rs1 = rs1; x.rs1_rd = rs1_rd; x.rs2 = rs2; x.rs2_rd = rs2_rd;
        x.is_load = is_load; x.rd = rd; x.br = br; x.tgt = tgt; x.mem_busy = mb;
        return x;
    endfunction

    task automatic applyStimulus(input in_t x);
        @(negedge clk);
        rst = x.rst; id_rs1 = x.rs1; id_rs2 = x.rs2; ex_rd = x.rd;
        id_rs1_rd = x.rs1_rd; id_rs2_rd = x.rs2_rd; ex_is_load = x.is_load;
        ex_branch_taken = x.br; ex_branch_target = x.tgt;
        ex_div_start = x.div_start; div_done = x.div_done; mem_busy = x.mem_busy;
        trap_req = x.trap_req; trap_vector = x.vec;
        #1;
    endtask

    task automatic checkOutput(input string name, input out_t e);
        logic [43:0] act, expv;
        act  = {stall_o, flush_o, redirect_o, trap_ack_o, (e.redirect ? redirect_addr_o : 32'h0)};
        expv = {e.stall, e.flush, e.redirect, e.ack, (e.redirect ? e.addr : 32'h0)};
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("[TB] FAIL %s: got stall=%b flush=%b redir=%b ack=%b addr=%h, want stall=%b flush=%b redir=%b ack=%b addr=%h",
                      name, stall_o, flush_o, redirect_o, trap_ack_o, redirect_addr_o,
                      e.stall, e.flush, e.redirect, e.ack, e.addr);
    endtask

    task automatic checkCount(input string name, input logic [31:0] e);
        total_cnt++;
        if (stall_cycles_o === e) pass_cnt++;
        else $display("[TB] FAIL %s: stall_cycles got %0d want %0d", name, stall_cycles_o, e);
    endtask

    task automatic cyc(input string name, input in_t x, input out_t e);
        applyStimulus(x);
        checkOutput(name, e);
    endtask

    task automatic doReset();
        in_t x = idle_in();
        x.rst = 1;
        cyc("reset_outputs", x, mk_out(0, 0, 0, 0, 0));
    endtask

    // Model: one cycle of controller behaviour from the hazard rules
    task automatic model_step(input in_t x, output out_t e);
        bit hit;
        e = mk_out(0, 0, 0, 0, 0);
        if (x.rst) begin
            m_div = 0; m_drain = 0; m_jump = 0; m_vec = 0; m_cnt = 0;
            return;
        end
        if (m_jump) begin
            e = mk_out(5'b00000, 5'b00010, 1, m_vec, 1);
            m_jump = 0;
        end else if (m_drain) begin
            e = mk_out(5'b00001, 5'b01110, 0, 0, 0);
            if (!x.mem_busy) begin m_drain = 0; m_jump = 1; end
        end else if (m_div) begin
            if (x.div_done)      m_div = 0;
            else if (x.mem_busy) e = mk_out(5'b11111, 5'b00000, 0, 0, 0);
            else                 e = mk_out(5'b01111, 5'b10000, 0, 0, 0);
        end else begin
            hit = x.is_load && x.rd != 0 &&
                  ((x.rs1_rd && x.rs1 == x.rd) || (x.rs2_rd && x.rs2 == x.rd));
            if (x.trap_req) begin
                e = mk_out(5'b00001, 5'b01110, 0, 0, 0);
                m_vec = x.vec; m_drain = 1;
            end else if (x.mem_busy)  e = mk_out(5'b11111, 5'b00000, 0, 0, 0);
            else if (x.div_start) begin
                e = mk_out(5'b01111, 5'b10000, 0, 0, 0);
                m_div = 1;
            end else if (x.br)        e = mk_out(5'b00000, 5'b00110, 1, x.tgt, 0);
            else if (hit)             e = mk_out(5'b00011, 5'b00100, 0, 0, 0);
        end
        m_cnt = m_cnt + {31'b0, e.stall[0]};
    endtask

    initial begin
        vec_t        tbl[10];
        in_t         x;
        out_t        z, e;
        logic [31:0] cnt_exp;
        logic [31:0] hold_vec;
        bit          trap_hold;

        z = mk_out(0, 0, 0, 0, 0);
        tbl[0] = '{in: idle_in(),                                     exp: z};
        tbl[1] = '{in: lu_in(5, 1, 0, 0, 1, 5, 0, 0, 0),              exp: mk_out(5'b00011, 5'b00100, 0, 0, 0)};
        tbl[2] = '{in: lu_in(3, 1, 7, 1, 1, 7, 0, 0, 0),              exp: mk_out(5'b00011, 5'b00100, 0, 0, 0)};
        tbl[3] = '{in: lu_in(0, 1, 0, 1, 1, 0, 0, 0, 0),              exp: z};
        tbl[4] = '{in: lu_in(9, 0, 2, 1, 1, 9, 0, 0, 0),              exp: z};
        tbl[5] = '{in: lu_in(9, 1, 0, 0, 0, 9, 0, 0, 0),              exp: z};
        tbl[6] = '{in: lu_in(5, 1, 0, 0, 1, 5, 1, 32'h80, 0),         exp: mk_out(5'b00000, 5'b00110, 1, 32'h80, 0)};
        tbl[7] = '{in: lu_in(0, 0, 0, 0, 0, 0, 1, 32'h40, 1),         exp: mk_out(5'b11111, 5'b00000, 0, 0, 0)};
        tbl[8] = '{in: lu_in(4, 1, 0, 0, 1, 4, 0, 0, 1),              exp: mk_out(5'b11111, 5'b00000, 0, 0, 0)};
        tbl[9] = '{in: lu_in(0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEE0, 0),  exp: mk_out(5'b00000, 5'b00110, 1, 32'hDEAD_BEE0, 0)};

        doReset();
        applyStimulus(idle_in());
        checkCount("count_after_reset", 0);

        // Single-cycle RUN vectors
        cnt_exp = 0;
        for (int i = 0; i < 10; i++) begin
            cyc($sformatf("vec%0d", i), tbl[i].in, tbl[i].exp);
            cnt_exp = cnt_exp + {31'b0, tbl[i].exp.stall[0]};
        end
        applyStimulus(idle_in());
        checkCount("count_after_table", cnt_exp);

        // Load-use stalls exactly one cycle; x0 destination never stalls
        doReset();
        cyc("lu_stall", lu_in(5, 1, 0, 0, 1, 5, 0, 0, 0), mk_out(5'b00011, 5'b00100, 0, 0, 0));
        cyc("lu_release", idle_in(), z);
        checkCount("lu_count", 1);
        cyc("lu_rd0", lu_in(0, 1, 0, 0, 1, 0, 0, 0, 0), z);
        applyStimulus(idle_in());
        checkCount("lu_rd0_count", 1);

        // Divide: start at cycle 0, done at cycle 4
        doReset();
        x = idle_in(); x.div_start = 1;
        cyc("div_c0", x, mk_out(5'b01111, 5'b10000, 0, 0, 0));
        for (int c = 1; c < 4; c++)
            cyc($sformatf("div_c%0d", c), idle_in(), mk_out(5'b01111, 5'b10000, 0, 0, 0));
        x = idle_in(); x.div_done = 1;
        cyc("div_done", x, z);
        x = idle_in(); x.br = 1; x.tgt = 32'h44;
        cyc("div_back_to_run", x, mk_out(5'b00000, 5'b00110, 1, 32'h44, 0));
        checkCount("div_count", 4);

        // Trap with two cycles of memory wait
        doReset();
        x = idle_in(); x.trap_req = 1; x.vec = 32'h100; x.mem_busy = 1;
        cyc("trap_req", x, mk_out(5'b00001, 5'b01110, 0, 0, 0));
        cyc("trap_drain_busy", x, mk_out(5'b00001, 5'b01110, 0, 0, 0));
        x.mem_busy = 0; x.vec = 32'h999;
        cyc("trap_drain_free", x, mk_out(5'b00001, 5'b01110, 0, 0, 0));
        cyc("trap_jump", x, mk_out(5'b00000, 5'b00010, 1, 32'h100, 1));
        cyc("trap_after", idle_in(), z);
        checkCount("trap_count", 3);

        // Trap raised during a divide waits for the divide to finish
        doReset();
        x = idle_in(); x.div_start = 1;
        cyc("tdiv_start", x, mk_out(5'b01111, 5'b10000, 0, 0, 0));
        x = idle_in(); x.trap_req = 1; x.vec = 32'h200;
        cyc("tdiv_ignored", x, mk_out(5'b01111, 5'b10000, 0, 0, 0));
        x.div_done = 1;
        cyc("tdiv_done", x, z);
        x.div_done = 0;
        cyc("tdiv_req", x, mk_out(5'b00001, 5'b01110, 0, 0, 0));
        cyc("tdiv_drain", x, mk_out(5'b00001, 5'b01110, 0, 0, 0));
        cyc("tdiv_jump", x, mk_out(5'b00000, 5'b00010, 1, 32'h200, 1));

        // Reset during drain abandons the trap
        doReset();
        x = idle_in(); x.trap_req = 1; x.vec = 32'h300; x.mem_busy = 1;
        cyc("rtrap_req", x, mk_out(5'b00001, 5'b01110, 0, 0, 0));
        cyc("rtrap_drain", x, mk_out(5'b00001, 5'b01110, 0, 0, 0));
        x = idle_in(); x.rst = 1;
        cyc("rtrap_rst", x, z);
        cyc("rtrap_after", idle_in(), z);
        checkCount("rtrap_count", 0);
        cyc("rtrap_still_idle", idle_in(), z);

        // Randomized run against the model
        doReset();
        m_div = 0; m_drain = 0; m_jump = 0; m_vec = 0; m_cnt = 0;
        trap_hold = 0; hold_vec = 0;
        for (int n = 0; n < 3000; n++) begin
            x = idle_in();
            x.rs1 = 5'($urandom_range(0, 3)); x.rs2 = 5'($urandom_range(0, 3));
            x.rd  = 5'($urandom_range(0, 3));
            x.rs1_rd = 1'($urandom); x.rs2_rd = 1'($urandom); x.is_load = 1'($urandom);
            x.br = ($urandom_range(0, 3) == 0); x.tgt = $urandom;
            x.mem_busy = ($urandom_range(0, 3) == 0);
            if (m_div) x.div_done = ($urandom_range(0, 3) == 0);
            else       x.div_start = ($urandom_range(0, 7) == 0);
            if (!trap_hold && $urandom_range(0, 15) == 0) begin
                trap_hold = 1; hold_vec = $urandom;
            end
            x.trap_req = trap_hold; x.vec = trap_hold ? hold_vec : $urandom;
            x.rst = ($urandom_range(0, 63) == 0);
            if (x.rst) begin trap_hold = 0; x.trap_req = 0; end
            cnt_exp = m_cnt;
            model_step(x, e);
            if (e.ack) trap_hold = 0;
            cyc($sformatf("rand%0d", n), x, e);
            checkCount($sformatf("rand_count%0d", n), cnt_exp);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central hazard and sequencing controller for the five-stage pipeline: PC, IF/ID, ID/EX, EX/MEM, MEM/WB. It decides per cycle which pipeline registers hold (stall) and which load a bubble (flush), and redirects the PC on taken branches and traps. It also sequences multi-cycle divides, memory wait states and the drain-then-jump trap entry. It counts stalled cycles for performance monitoring.

## Interface
- ADDR_W, 32, PC / target width (matches `InstAddrBus`)
- REG_IDX_W, 5, register index width
- CNT_W, 32, stall counter width
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high; clock clk
- id_rs1, id_rs2  in  REG_IDX_W  source indices of instruction in ID
- id_rs1_rd, id_rs2_rd  in  1  source actually read
- ex_is_load  in  1  instruction in EX is a load
- ex_rd  in  REG_IDX_W  destination of instruction in EX
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- ex_branch_target  in  ADDR_W  its target
- ex_div_start  in  1  divide issued in EX this cycle
- div_done  in  1  divider result valid (1-cycle pulse)
- mem_busy  in  1  data bus wait state
- trap_req  in  1  trap request, held high until trap_ack_o
- trap_vector  in  ADDR_W  trap handler address
- stall_o  out  5  hold enable per stage, bit0=PC … bit4=MEM/WB
- flush_o  out  5  bubble (load `Zero` / NOP) per stage, same indexing
- redirect_o  out  1  load PC from redirect_addr_o
- redirect_addr_o  out  ADDR_W  new PC
- trap_ack_o  out  1  trap taken (1-cycle pulse)
- stall_cycles_o  out  CNT_W  count of cycles with stall_o[0]=1

## Operation
- FSM states: RUN, DIV_WAIT, TRAP_DRAIN, TRAP_JUMP; reset → RUN, vector latch 0, counter 0.
- stall_o/flush_o/redirect_o/redirect_addr_o/trap_ack_o are combinational from state and inputs. All are 0 whenever rst=1.
- RUN, priority high→low:
  - trap_req: flush_o=5'b01110, stall_o=5'b00001. Latch trap_vector. Next state TRAP_DRAIN.
  - mem_busy: stall_o=5'b11111, flush_o=0, stay.
  - ex_div_start: stall_o=5'b01111, flush_o=5'b10000. Next state DIV_WAIT.
  - ex_branch_taken: redirect_o=1, redirect_addr_o=ex_branch_target, flush_o=5'b00110, stall_o=0.
  - load-use: ex_is_load && ex_rd!=0 && ((id_rs1_rd && id_rs1==ex_rd) || (id_rs2_rd && id_rs2==ex_rd)). Response: stall_o=5'b00011, flush_o=5'b00100.
  - else all 0.
- DIV_WAIT:
  - While !div_done: stall_o=5'b01111, flush_o=5'b10000; mem_busy overrides to stall_o=5'b11111, flush_o=0.
  - div_done: outputs 0, next RUN.
  - trap_req here is not taken. It stays pending (requester holds it) and is evaluated in RUN.
- TRAP_DRAIN: stall_o=5'b00001, flush_o=5'b01110. Remain while mem_busy; next TRAP_JUMP when mem_busy=0.
- TRAP_JUMP: redirect_o=1, redirect_addr_o=latched vector, trap_ack_o=1, flush_o=5'b00010. Next RUN.
- Branch in EX during trap entry is discarded by the EX flush. Load-use is ignored outside RUN.
- stall_cycles_o: +1 each cycle stall_o[0]=1; wraps modulo 2^CNT_W; cleared only by rst.

## Timing
- Hazard outputs are same-cycle (zero latency) in RUN. They take effect at the next clk edge in the pipeline registers.
- Trap: request cycle + ≥1 drain cycle + jump cycle. Minimum 3 cycles from trap_req to first handler fetch in IF/ID.
- Divide: stall spans the ex_div_start cycle through the cycle before div_done. div_done with ex_div_start in the same cycle is illegal.
- rst mid-sequence: next state RUN, vector and counter cleared, pending redirect discarded.

## Structure
- Shared define.vh: stage bit indices (`StgPc`…`StgWb`), FSM state encodings, `Enabled`/`Zero`, `InstAddrBus`.
- Single module; the hazard comparator is a natural sub-module `load_use_det` (pure combinational).

## Test plan
- Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_rs1_rd=1 → stall_o=00011, flush_o=00100 for one cycle; stall_cycles_o=1. Repeat with ex_rd=0 → no stall.
- Branch + load-use same cycle, target 0x80 → redirect_o=1, redirect_addr_o=0x80, flush_o=00110, stall_o=0.
- Divide: ex_div_start at cycle 0, div_done at cycle 4 → stall_o=01111 cycles 0–3, 0 at cycle 4; state RUN at 5; counter=4.
- Trap with mem_busy high 2 cycles, vector 0x100 → TRAP_DRAIN 2 cycles then TRAP_JUMP. Expect redirect 0x100 and trap_ack_o pulse at cycle 3 only.
- trap_req during DIV_WAIT → ignored until div_done; TRAP_DRAIN entered the cycle after return to RUN.
- rst asserted in TRAP_DRAIN → next cycle RUN, all outputs 0, no trap_ack_o.
